// File: rtl/imem_loader.sv
// Boot loader for the instruction memory: packs a little-endian byte stream into
// 32-bit words, writes them from address 0 and holds the CPU until a program is present.
module imem_loader #(
    parameter int unsigned ADDR_W   = 6,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [31:0]       cpu_data,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   loaded_words
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1 << ADDR_W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] target;
    logic [1:0]       byte_idx;
    logic [31:0]      word_buf;
    logic             prog_valid;

    logic             start_fire_c;
    logic             byte_fire_c;
    logic             last_word_c;
    logic [CNT_W-1:0] target_c;

    // Next-state logic; byte acceptance is qualified by the registered byte_ready.
    always_comb begin
        start_fire_c = start && (state == S_IDLE);
        target_c     = (word_count > DEPTH) ? DEPTH : word_count;
        byte_fire_c  = byte_valid && byte_ready;
        last_word_c  = ((loaded_words + CNT_W'(1)) == target);
        state_nxt    = state;
        case (state)
            S_IDLE:  if (start_fire_c && (target_c != '0)) state_nxt = S_RECV;
            S_RECV:  if (byte_fire_c && (byte_idx == 2'd3)) state_nxt = S_WRITE;
            S_WRITE: state_nxt = last_word_c ? S_IDLE : S_RECV;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            target       <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
            prog_valid   <= 1'b0;
            loaded_words <= '0;
            done         <= 1'b0;
            byte_ready   <= 1'b0;
            busy         <= 1'b0;
            mem_we       <= 1'b0;
        end else begin
            state      <= state_nxt;
            byte_ready <= (state_nxt == S_RECV);
            busy       <= (state_nxt != S_IDLE);
            mem_we     <= (state_nxt == S_WRITE);
            done       <= 1'b0;

            if (start_fire_c) begin
                target       <= target_c;
                loaded_words <= '0;
                byte_idx     <= '0;
                // An empty load completes immediately; otherwise the CPU stays held.
                prog_valid   <= (target_c == '0);
                done         <= (target_c == '0);
            end

            if (byte_fire_c) begin
                word_buf[{byte_idx, 3'b000} +: 8] <= byte_data;
                byte_idx                          <= byte_idx + 2'd1;
            end

            if (state == S_WRITE) begin
                loaded_words <= loaded_words + CNT_W'(1);
                if (last_word_c) begin
                    prog_valid <= 1'b1;
                    done       <= 1'b1;
                end
            end
        end
    end

    assign mem_waddr = loaded_words[ADDR_W-1:0];
    assign mem_wdata = word_buf;
    assign mem_raddr = cpu_addr;
    assign cpu_hold  = busy || !prog_valid;
    assign cpu_data  = cpu_hold ? NOP_WORD : mem_rdata;

endmodule
